tick_period_monitor: RTL and testbench

- Receive-side checker for the periodic one-cycle overflow pulse produced by the team's enable-gated counter state machine.
- Measures the cycle distance between consecutive tick pulses and compares it against an expected period with tolerance.
- Flags early and missing ticks, and asserts a lock indication after a run of good periods.
- Sits beside the tick generator in the timing subsystem as its functional monitor and health status source.

---
 rtl/tick_period_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_tick_period_monitor.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tick_period_monitor
//
// Receive-side checker for a periodic one-cycle tick pulse. It measures the
// number of cycles between consecutive ticks and compares each measured period
// with EXP_PERIOD +/- TOL. It flags ticks that arrive early and ticks that do
// not arrive in time. After LOCK_CNT consecutive in-tolerance periods it
// reports lock.
//
// Optional feature (macro TICK_MON_STICKY_EN):
//   When this macro is defined, the block adds the err_clr input and the
//   err_sticky output. err_sticky is a sticky error flag that err_clr clears.
//   If an error and err_clr occur in the same cycle, the set wins.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   resetN       in   1   asynchronous active-low reset
//   enable       in   1   monitor enable; low forces IDLE
//   tick_in      in   1   one-cycle tick pulse under test
//   err_clr      in   1   (TICK_MON_STICKY_EN only) clear for err_sticky
//   locked       out  1   high while in LOCKED
//   err_early    out  1   one-cycle pulse: period < EXP_PERIOD-TOL
//   err_missing  out  1   one-cycle pulse: no tick by EXP_PERIOD+TOL
//   last_period  out  CW  last measured period in cycles
//   err_count    out  16  saturating count of error pulses
//   err_sticky   out  1   (TICK_MON_STICKY_EN only) sticky error flag
// -----------------------------------------------------------------------------
module tick_period_monitor #(
  parameter int unsigned EXP_PERIOD = 6,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned CW         = 32
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          enable,
  input  logic          tick_in,
`ifdef TICK_MON_STICKY_EN
  input  logic          err_clr,
  output logic          err_sticky,
`endif
  output logic          locked,
  output logic          err_early,
  output logic          err_missing,
  output logic [CW-1:0] last_period,
  output logic [15:0]   err_count
);

  localparam int unsigned GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  // Periods strictly below this limit are early.
  localparam logic [CW:0]   EARLY_LIM = (CW+1)'(EXP_PERIOD - TOL);
  // This is the gap value on the last cycle on which a tick is still on time.
  localparam logic [CW-1:0] MISS_GAP  = CW'(EXP_PERIOD + TOL - 1);
  localparam logic [CW-1:0] GAP_MAX   = {CW{1'b1}};
  localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    MEASURE = 2'b10,
    LOCKED  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [GW-1:0]   good_q, good_d;
  logic            locked_q, locked_d;
  logic            early_q, early_d;
  logic            missing_q, missing_d;
  logic [CW-1:0]   last_q, last_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [CW:0]     period_s;
  logic [CW-1:0]   gap_inc_s;
  logic [GW-1:0]   good_inc_s;
  logic            err_evt_s;

  // Next-state logic for the FSM, the gap counter, the period record and the error pulses.
  always_comb begin
    state_d   = state_q;
    gap_inc_s = (gap_q == GAP_MAX) ? gap_q : gap_q + CW'(1);
    gap_d     = gap_inc_s;
    good_inc_s = (good_q == GOOD_MAX) ? good_q : good_q + GW'(1);
    good_d    = good_q;
    early_d   = 1'b0;
    missing_d = 1'b0;
    last_d    = last_q;
    // The extra bit keeps gap+1 from wrapping when the gap is saturated.
    period_s  = {1'b0, gap_q} + {{CW{1'b0}}, 1'b1};

    if (!enable) begin
      state_d = IDLE;
      gap_d   = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A tick in this cycle is deliberately ignored.
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (tick_in) begin
            state_d = MEASURE;
            gap_d   = '0;
          end else begin
            state_d = ACQUIRE;
          end
        end
        MEASURE, LOCKED: begin
          if (tick_in) begin
            gap_d  = '0;
            last_d = period_s[CW-1:0];
            if (period_s < EARLY_LIM) begin
              early_d = 1'b1;
              good_d  = '0;
              state_d = MEASURE;
            end else begin
              good_d = good_inc_s;
              // good_cnt stays saturated while locked, so LOCKED holds.
              if (good_inc_s == GOOD_MAX) begin
                state_d = LOCKED;
              end else begin
                state_d = MEASURE;
              end
            end
          end else if (gap_q == MISS_GAP) begin
            // A late tick only re-arms measurement through ACQUIRE.
            missing_d = 1'b1;
            good_d    = '0;
            state_d   = ACQUIRE;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = IDLE;
          gap_d   = '0;
          good_d  = '0;
        end
      endcase
    end

    locked_d  = (state_d == LOCKED);
    err_evt_s = early_d | missing_d;
    if (err_evt_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Register the FSM state, the counters and all outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      early_q   <= 1'b0;
      missing_q <= 1'b0;
      last_q    <= '0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      early_q   <= early_d;
      missing_q <= missing_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign locked      = locked_q;
  assign err_early   = early_q;
  assign err_missing = missing_q;
  assign last_period = last_q;
  assign err_count   = cnt_q;

`ifdef TICK_MON_STICKY_EN
  logic sticky_q, sticky_d;

  // Sticky flag next state: an error pulse sets the flag, and the set overrides err_clr.
  always_comb begin
    if (err_evt_s) begin
      sticky_d = 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Register the sticky error flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
module tb_tick_period_monitor;

  localparam int EXP  = 6;
  localparam int TOL  = 0;
  localparam int LOCK = 3;

  logic        clk = 1'b0;
  logic        resetN, enable, tick_in;
  logic        locked, err_early, err_missing;
  logic [31:0] last_period;
  logic [15:0] err_count;

  logic        enable2, tick2;
  logic        locked2, err_early2, err_missing2;
  logic [31:0] last_period2;
  logic [15:0] err_count2;

`ifdef TICK_MON_STICKY_EN
  logic err_clr, err_sticky, err_clr2, err_sticky2;
`endif

  always #5 clk = ~clk;

  tick_period_monitor #(.EXP_PERIOD(6), .TOL(0), .LOCK_CNT(3), .CW(32)) u_dut (
    .clk(clk), .resetN(resetN), .enable(enable), .tick_in(tick_in),
`ifdef TICK_MON_STICKY_EN
    .err_clr(err_clr), .err_sticky(err_sticky),
`endif
    .locked(locked), .err_early(err_early), .err_missing(err_missing),
    .last_period(last_period), .err_count(err_count)
  );

  tick_period_monitor #(.EXP_PERIOD(6), .TOL(1), .LOCK_CNT(3), .CW(32)) u_dut_tol1 (
    .clk(clk), .resetN(resetN), .enable(enable2), .tick_in(tick2),
`ifdef TICK_MON_STICKY_EN
    .err_clr(err_clr2), .err_sticky(err_sticky2),
`endif
    .locked(locked2), .err_early(err_early2), .err_missing(err_missing2),
    .last_period(last_period2), .err_count(err_count2)
  );

  typedef struct packed {
    logic        lk;
    logic        ee;
    logic        em;
    logic [31:0] lp;
    logic [15:0] ec;
    logic        st;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: 0 idle, 1 acquire, 2 measure, 3 locked
  int   m_state, m_gap, m_good, m_last, m_cnt;
  bit   m_early, m_missing, m_sticky;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_gap = 0; m_good = 0; m_last = 0; m_cnt = 0;
    m_early = 0; m_missing = 0; m_sticky = 0;
  endtask

  task automatic model_step(input bit en, input bit tk, input bit clr);
    exp_t e;
    int   p;
    m_early   = 0;
    m_missing = 0;
    if (!en) begin
      m_state = 0; m_gap = 0; m_good = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_gap++;
    end else if (m_state == 1) begin
      if (tk) begin m_state = 2; m_gap = 0; end
      else m_gap++;
    end else begin
      if (tk) begin
        p = m_gap + 1;
        m_last = p;
        m_gap = 0;
        if (p < EXP - TOL) begin
          m_early = 1; m_good = 0; m_state = 2;
        end else begin
          if (m_good < LOCK) m_good++;
          m_state = (m_good == LOCK) ? 3 : 2;
        end
      end else if (m_gap == EXP + TOL - 1) begin
        m_missing = 1; m_good = 0; m_state = 1; m_gap++;
      end else begin
        m_gap++;
      end
    end
    if ((m_early || m_missing) && m_cnt < 65535) m_cnt++;
    if (m_early || m_missing) m_sticky = 1;
    else if (clr) m_sticky = 0;
    e.lk = (m_state == 3);
    e.ee = m_early;
    e.em = m_missing;
    e.lp = m_last;
    e.ec = m_cnt;
    e.st = m_sticky;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit en, input bit tk);
    exp_t e;
    bit   clr;
    clr = 1'b0;
    @(negedge clk);
    enable  = en;
    tick_in = tk;
`ifdef TICK_MON_STICKY_EN
    clr = err_clr;
`endif
    model_step(en, tk, clr);
    @(posedge clk);
    #1;
    check_val("sb_not_empty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val("locked", 64'(locked), 64'(e.lk));
      check_val("err_early", 64'(err_early), 64'(e.ee));
      check_val("err_missing", 64'(err_missing), 64'(e.em));
      check_val("last_period", 64'(last_period), 64'(e.lp));
      check_val("err_count", 64'(err_count), 64'(e.ec));
`ifdef TICK_MON_STICKY_EN
      check_val("err_sticky", 64'(err_sticky), 64'(e.st));
`endif
    end
  endtask

  // (k-1) idle cycles followed by a tick: a period of k
  task automatic run_gap(input int k);
    for (int i = 0; i < k - 1; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
  endtask

  task automatic step2(input bit en, input bit tk);
    @(negedge clk);
    enable2 = en;
    tick2   = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic run_gap2(input int k);
    for (int i = 0; i < k - 1; i++) step2(1'b1, 1'b0);
    step2(1'b1, 1'b1);
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; tick_in = 1'b0;
    enable2 = 1'b0; tick2 = 1'b0;
`ifdef TICK_MON_STICKY_EN
    err_clr = 1'b0; err_clr2 = 1'b0;
`endif
    model_reset();
    #12;
    check_val("rst_locked", 64'(locked), 64'd0);
    check_val("rst_last_period", 64'(last_period), 64'd0);
    check_val("rst_err_count", 64'(err_count), 64'd0);
    check_val("rst_err_early", 64'(err_early), 64'd0);
    check_val("rst_err_missing", 64'(err_missing), 64'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Nominal 6-cycle ticks: lock after the 4th tick
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    run_gap(6);
    check_val("p6_after_2nd", 64'(last_period), 64'd6);
    run_gap(6);
    check_val("not_locked_3rd", 64'(locked), 64'd0);
    run_gap(6);
    check_val("locked_4th", 64'(locked), 64'd1);
    check_val("no_err_nominal", 64'(err_count), 64'd0);

    // Early tick while locked, then relock
    run_gap(4);
    check_val("early_pulse", 64'(err_early), 64'd1);
    check_val("early_period", 64'(last_period), 64'd4);
    check_val("early_unlock", 64'(locked), 64'd0);
    check_val("early_count", 64'(err_count), 64'd1);
    step(1'b1, 1'b0);
    check_val("early_one_cycle", 64'(err_early), 64'd0);
    run_gap(5);
    run_gap(6);
    check_val("relock_pending", 64'(locked), 64'd0);
    run_gap(6);
    check_val("relocked", 64'(locked), 64'd1);

    // Tick stream stops: a single missing pulse
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check_val("no_missing_yet", 64'(err_missing), 64'd0);
    step(1'b1, 1'b0);
    check_val("missing_pulse", 64'(err_missing), 64'd1);
    check_val("missing_unlock", 64'(locked), 64'd0);
    check_val("missing_count", 64'(err_count), 64'd2);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check_val("missing_once", 64'(err_count), 64'd2);
    step(1'b1, 1'b1);
    check_val("late_no_error", 64'(err_count), 64'd2);
    run_gap(6);
    run_gap(6);
    run_gap(6);
    check_val("lock_after_rearm", 64'(locked), 64'd1);

    // Enable dropped mid-period, then raised
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_val("disable_unlock", 64'(locked), 64'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_val("reenable_hold_period", 64'(last_period), 64'd6);
    check_val("reenable_no_err", 64'(err_count), 64'd2);
    run_gap(3);
    check_val("reenable_measures", 64'(last_period), 64'd3);

    // Reset in the middle of LOCKED
    run_gap(6);
    run_gap(6);
    run_gap(6);
    check_val("locked_before_rst", 64'(locked), 64'd1);
    step(1'b1, 1'b0);
    #2;
    resetN = 1'b0;
    #1;
    check_val("async_rst_locked", 64'(locked), 64'd0);
    check_val("async_rst_period", 64'(last_period), 64'd0);
    check_val("async_rst_count", 64'(err_count), 64'd0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;

`ifdef TICK_MON_STICKY_EN
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    run_gap(3);
    check_val("sticky_set", 64'(err_sticky), 64'd1);
    err_clr = 1'b1;
    step(1'b1, 1'b0);
    err_clr = 1'b0;
    check_val("sticky_clr", 64'(err_sticky), 64'd0);
    err_clr = 1'b1;
    step(1'b1, 1'b1);
    err_clr = 1'b0;
    check_val("sticky_set_wins", 64'(err_sticky), 64'd1);
    check_val("sticky_err_early", 64'(err_early), 64'd1);
`endif

    // TOL=1 instance: periods 5, 7, 6 in tolerance; 4 is early
    step2(1'b1, 1'b0);
    step2(1'b1, 1'b1);
    run_gap2(5);
    check_val("tol1_p5", 64'(last_period2), 64'd5);
    run_gap2(7);
    check_val("tol1_p7_noerr", 64'(err_count2), 64'd0);
    run_gap2(6);
    check_val("tol1_locked", 64'(locked2), 64'd1);
    run_gap2(4);
    check_val("tol1_early", 64'(err_early2), 64'd1);
    check_val("tol1_p4", 64'(last_period2), 64'd4);
    check_val("tol1_count", 64'(err_count2), 64'd1);
    check_val("tol1_unlock", 64'(locked2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
